// File: rtl/prog_run_ctrl_pkg.sv
// rtl/prog_run_ctrl_pkg.sv - shared state type and index helper for the run controller
package prog_run_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, INIT, RUN, ABORT, FIN} run_state_t;

  // Round-robin scan position: step places after base, wrapping at n.
  function automatic int rr_wrap(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/prog_run_ctrl_rr_arbiter.sv
// rtl/prog_run_ctrl_rr_arbiter.sv - combinational round-robin pick starting after the last owner
module rr_arbiter
  import prog_run_ctrl_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         gnt_next,
  output logic [$clog2(N_REQ)-1:0] idx_next
);

  localparam int IDX_W = $clog2(N_REQ);

  int   idx;
  logic found;

  always_comb begin
    gnt_next = '0;
    idx_next = '0;
    found    = 1'b0;
    idx      = 0;
    // The previous owner is scanned last, so it only wins when nobody else asks.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = rr_wrap(int'(last), i, N_REQ);
      if (!found && req[IDX_W'(idx)]) begin
        found                 = 1'b1;
        gnt_next[IDX_W'(idx)] = 1'b1;
        idx_next              = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/prog_run_ctrl.sv
// rtl/prog_run_ctrl.sv - shares one datapath between requesters and sequences start, run and watchdog
module prog_run_ctrl
  import prog_run_ctrl_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int START_CYC = 2,
  parameter int CNT_W     = 16,
  parameter int MAX_CYC   = 50000
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] prog_sel,
  output logic                     dp_start,
  input  logic                     dp_done,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic [CNT_W-1:0]         cycles,
  output logic                     timeout
);

  localparam int               IDX_W   = $clog2(N_REQ);
  localparam int               PH_W    = $clog2(START_CYC + 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYC);

  run_state_t       state;
  logic [IDX_W-1:0] last;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_nxt;
  logic [N_REQ-1:0] gnt_next;
  logic [IDX_W-1:0] idx_next;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req      (req),
    .last     (last),
    .gnt_next (gnt_next),
    .idx_next (idx_next)
  );

  assign run_nxt = run_cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      prog_sel <= '0;
      last     <= IDX_W'(N_REQ - 1);
      ack      <= '0;
      busy     <= 1'b0;
      cycles   <= '0;
      timeout  <= 1'b0;
      dp_start <= 1'b1;
      phase    <= '0;
      run_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= gnt_next;
            prog_sel <= idx_next;
            last     <= idx_next;
            busy     <= 1'b1;
            phase    <= '0;
            state    <= INIT;
          end
        end
        INIT: begin
          if (phase == PH_LAST) begin
            run_cnt  <= '0;
            dp_start <= 1'b0;
            state    <= RUN;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        RUN: begin
          run_cnt <= run_nxt;
          // A done on the watchdog's final cycle still counts as a normal finish.
          if (dp_done) begin
            cycles  <= run_nxt;
            timeout <= 1'b0;
            ack     <= grant;
            state   <= FIN;
          end else if (run_nxt == CNT_MAX) begin
            dp_start <= 1'b1;
            state    <= ABORT;
          end
        end
        ABORT: begin
          // Result registers only move on the way into FIN.
          cycles   <= CNT_MAX;
          timeout  <= 1'b1;
          ack      <= grant;
          dp_start <= 1'b0;
          state    <= FIN;
        end
        FIN: begin
          ack      <= '0;
          grant    <= '0;
          busy     <= 1'b0;
          dp_start <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
